// File: rtl/video_timing_compositor.sv
// Raster timing generator, PIPE_DELAY-aligned sync/blank/DE delay line and fixed-priority layer compositor.
// Optional colour-bar test pattern: define VIDEO_TEST_PATTERN_EN to add the test_pattern input.
module video_timing_compositor #(
  parameter int H_ACTIVE   = 360,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 32,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 360,
  parameter int V_FP       = 4,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 12,
  parameter int PIPE_DELAY = 2,
  parameter int NUM_LAYERS = 2,
  parameter int CW         = 10
) (
  input  logic                    clk_vid_32_768,
  input  logic                    reset_n,
`ifdef VIDEO_TEST_PATTERN_EN
  input  logic                    test_pattern,
`endif
  input  logic [24*NUM_LAYERS-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]   layer_en,
  output logic [CW-1:0]           video_x,
  output logic [CW-1:0]           video_y,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    hblank,
  output logic                    vblank,
  output logic                    de,
  output logic [23:0]             rgb,
  output logic                    frame_start,
  output logic                    line_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  if (H_TOTAL > 2**CW || V_TOTAL > 2**CW) begin : g_bad_cw
    $error("video_timing_compositor: H_TOTAL/V_TOTAL do not fit in CW bits");
  end
  if (PIPE_DELAY < 1 || PIPE_DELAY > 8) begin : g_bad_delay
    $error("video_timing_compositor: PIPE_DELAY must be 1..8");
  end
  if (NUM_LAYERS < 1 || NUM_LAYERS > 8) begin : g_bad_layers
    $error("video_timing_compositor: NUM_LAYERS must be 1..8");
  end

  typedef struct packed {
    logic hs;
    logic vs;
    logic hb;
    logic vb;
    logic de;
    logic fs;
    logic ls;
  } tim_t;

  localparam tim_t TIM_BLANK = '{hs: 1'b0, vs: 1'b0, hb: 1'b1, vb: 1'b1,
                                 de: 1'b0, fs: 1'b0, ls: 1'b0};

  // Highest-index enabled layer wins; layer 0 doubles as the background.
  function automatic logic [23:0] composite(input logic [24*NUM_LAYERS-1:0] pix,
                                            input logic [NUM_LAYERS-1:0] en);
    logic [23:0] sel;
    sel = pix[23:0];
    for (int i = 0; i < NUM_LAYERS; i++)
      if (en[i]) sel = pix[24*i +: 24];
    return sel;
  endfunction

`ifdef VIDEO_TEST_PATTERN_EN
  function automatic logic [23:0] bar_colour(input logic [CW-1:0] x);
    int bar;
    bar = (int'(x) * 8) / H_ACTIVE;
    case (bar)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction
`endif

  logic [CW-1:0] x_cnt;
  logic [CW-1:0] y_cnt;
  tim_t          raw;
  tim_t          tim_pd [PIPE_DELAY];
  logic          de_a;

  // Stage p0: raster counters issued to the layer sources
  always_ff @(posedge clk_vid_32_768) begin
    if (!reset_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (x_cnt == H_LAST) begin
      x_cnt <= '0;
      y_cnt <= (y_cnt == V_LAST) ? '0 : y_cnt + CW'(1);
    end else begin
      x_cnt <= x_cnt + CW'(1);
    end
  end

  always_comb begin
    raw    = TIM_BLANK;
    raw.hb = int'(x_cnt) >= H_ACTIVE;
    raw.vb = int'(y_cnt) >= V_ACTIVE;
    raw.hs = int'(x_cnt) >= HS_START && int'(x_cnt) < HS_END;
    raw.vs = int'(y_cnt) >= VS_START && int'(y_cnt) < VS_END;
    raw.de = !raw.hb && !raw.vb;
    raw.fs = x_cnt == '0 && y_cnt == '0;
    raw.ls = x_cnt == '0;
  end

  // Stages p1..pPIPE_DELAY: timing delay line, flushed to blank on reset
  always_ff @(posedge clk_vid_32_768) begin
    if (!reset_n) begin
      for (int i = 0; i < PIPE_DELAY; i++) tim_pd[i] <= TIM_BLANK;
    end else begin
      tim_pd[0] <= raw;
      for (int i = 1; i < PIPE_DELAY; i++) tim_pd[i] <= tim_pd[i-1];
    end
  end

  // The rgb register samples one stage ahead of the timing outputs.
  if (PIPE_DELAY == 1) begin : g_de_raw
    assign de_a = raw.de;
  end else begin : g_de_dly
    assign de_a = tim_pd[PIPE_DELAY-2].de;
  end

`ifdef VIDEO_TEST_PATTERN_EN
  logic          tp_a;
  logic [CW-1:0] x_a;

  if (PIPE_DELAY == 1) begin : g_tp_raw
    assign tp_a = test_pattern;
    assign x_a  = x_cnt;
  end else begin : g_tp_dly
    logic          tp_d [PIPE_DELAY-1];
    logic [CW-1:0] x_d  [PIPE_DELAY-1];
    always_ff @(posedge clk_vid_32_768) begin
      tp_d[0] <= test_pattern;
      x_d[0]  <= x_cnt;
      for (int i = 1; i < PIPE_DELAY - 1; i++) begin
        tp_d[i] <= tp_d[i-1];
        x_d[i]  <= x_d[i-1];
      end
    end
    assign tp_a = tp_d[PIPE_DELAY-2];
    assign x_a  = x_d[PIPE_DELAY-2];
  end
`endif

  // Output stage: composited pixel, aligned with the delayed de
  always_ff @(posedge clk_vid_32_768) begin
    if (!reset_n)  rgb <= '0;
    else if (!de_a) rgb <= '0;
`ifdef VIDEO_TEST_PATTERN_EN
    else if (tp_a) rgb <= bar_colour(x_a);
`endif
    else           rgb <= composite(layer_rgb, layer_en);
  end

  assign video_x     = x_cnt;
  assign video_y     = y_cnt;
  assign hsync       = tim_pd[PIPE_DELAY-1].hs;
  assign vsync       = tim_pd[PIPE_DELAY-1].vs;
  assign hblank      = tim_pd[PIPE_DELAY-1].hb;
  assign vblank      = tim_pd[PIPE_DELAY-1].vb;
  assign de          = tim_pd[PIPE_DELAY-1].de;
  assign frame_start = tim_pd[PIPE_DELAY-1].fs;
  assign line_start  = tim_pd[PIPE_DELAY-1].ls;

endmodule

// File: tb/tb_video_timing_compositor.sv
// Scoreboard bench for video_timing_compositor on a small 16x8 raster with three layers.
module tb_video_timing_compositor;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = 16, VT = 8;  // totals for the timing above
  localparam int PD = 2;
  localparam int NL = 3;

  typedef struct packed {
    logic [9:0]  vx;
    logic [9:0]  vy;
    logic        hs, vs, hb, vb, de, fs, ls;
    logic [23:0] rgb;
  } obs_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [24*NL-1:0] layer_rgb;
  logic [NL-1:0]   layer_en;
  logic [9:0]      video_x, video_y;
  logic            hsync, vsync, hblank, vblank, de, frame_start, line_start;
  logic [23:0]     rgb;
`ifdef VIDEO_TEST_PATTERN_EN
  logic            test_pattern = 1'b0;
`endif

  video_timing_compositor #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIPE_DELAY(PD), .NUM_LAYERS(NL), .CW(10)
  ) dut (
    .clk_vid_32_768(clk),
    .reset_n(reset_n),
`ifdef VIDEO_TEST_PATTERN_EN
    .test_pattern(test_pattern),
`endif
    .layer_rgb(layer_rgb),
    .layer_en(layer_en),
    .video_x(video_x),
    .video_y(video_y),
    .hsync(hsync),
    .vsync(vsync),
    .hblank(hblank),
    .vblank(vblank),
    .de(de),
    .rgb(rgb),
    .frame_start(frame_start),
    .line_start(line_start)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  obs_t sb[$];
  int   tags[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   k = 0;
  int   mode = 0;

  // en = {L2,L1,L0}; layers are {0000FF, 00FF00, FF0000}
  logic [23:0] col_tab [8] = '{24'hFF0000, 24'hFF0000, 24'h00FF00, 24'h00FF00,
                               24'h0000FF, 24'h0000FF, 24'h0000FF, 24'h0000FF};
  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  // Expected outputs during cycle m after the last reset edge, showing pixel m-PD.
  function automatic obs_t expect_out(input int m, input logic [23:0] pix);
    obs_t e;
    int q, x, y;
    e    = '0;
    q    = m - PD;
    e.vx = 10'(m % HT);
    e.vy = 10'((m / HT) % VT);
    if (q < 0) begin
      e.hb = 1'b1;
      e.vb = 1'b1;
    end else begin
      x    = q % HT;
      y    = (q / HT) % VT;
      e.hb = x >= HA;
      e.vb = y >= VA;
      e.hs = x >= HA + HF && x < HA + HF + HS;
      e.vs = y >= VA + VF && y < VA + VF + VS;
      e.de = !e.hb && !e.vb;
      e.fs = x == 0 && y == 0;
      e.ls = x == 0;
      e.rgb = e.de ? pix : 24'h000000;
    end
    return e;
  endfunction

  task automatic drive_junk();
    layer_rgb = {NL{24'hABCDEF}};
    layer_en  = '1;
`ifdef VIDEO_TEST_PATTERN_EN
    test_pattern = 1'b0;
`endif
  endtask

  task automatic drive_pixel(input int q, output logic [23:0] pix);
    int x, y;
    logic [23:0] val;
    x = q % HT;
    y = (q / HT) % VT;
`ifdef VIDEO_TEST_PATTERN_EN
    test_pattern = 1'b0;
`endif
    pix = 24'h0;
    case (mode)
      0: begin
        layer_rgb = {24'h0000FF, 24'h00FF00, 24'hFF0000};
        layer_en  = 3'(q % 8);
        pix       = col_tab[q % 8];
      end
      1: begin
        val       = 24'(x + 256 * y);
        layer_rgb = {24'h123456, val, 24'hFEDCBA};
        layer_en  = 3'b011;
        pix       = val;
      end
      default: begin
`ifdef VIDEO_TEST_PATTERN_EN
        test_pattern = 1'b1;
`endif
        layer_rgb = {NL{24'h5A5A5A}};
        layer_en  = '1;
        if (x < 8) pix = bar_tab[x];
      end
    endcase
  endtask

  // One clock of stimulus; pushes what the DUT must show in the following cycle.
  task automatic step(input logic run);
    logic [23:0] pix;
    int q;
    if (!run) begin
      reset_n = 1'b0;
      drive_junk();
      sb.push_back(expect_out(0, 24'h0));
      tags.push_back(cyc + 1);
      @(posedge clk); #1;
      k = 0;
    end else begin
      reset_n = 1'b1;
      q = k - (PD - 1);
      pix = 24'h0;
      if (q < 0) drive_junk();
      else drive_pixel(q, pix);
      sb.push_back(expect_out(k + 1, pix));
      tags.push_back(cyc + 1);
      @(posedge clk); #1;
      k++;
    end
  endtask

  int last_fs  = 0;
  bit have_fs  = 1'b0;

  always @(negedge clk) begin
    obs_t got, e;
    got = '{vx: video_x, vy: video_y, hs: hsync, vs: vsync, hb: hblank, vb: vblank,
            de: de, fs: frame_start, ls: line_start, rgb: rgb};
    while (tags.size() > 0 && tags[0] < cyc) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_stale: entry for cycle %0d not compared, now %0d", tags[0], cyc);
      void'(tags.pop_front());
      void'(sb.pop_front());
    end
    if (tags.size() > 0 && tags[0] == cyc) begin
      e = sb.pop_front();
      void'(tags.pop_front());
      n_checks++;
      if (got !== e) begin
        n_errors++;
        $display("FAIL out@%0d: got x=%0d y=%0d hs%b vs%b hb%b vb%b de%b fs%b ls%b rgb=%h; want x=%0d y=%0d hs%b vs%b hb%b vb%b de%b fs%b ls%b rgb=%h",
                 cyc, got.vx, got.vy, got.hs, got.vs, got.hb, got.vb, got.de, got.fs, got.ls, got.rgb,
                 e.vx, e.vy, e.hs, e.vs, e.hb, e.vb, e.de, e.fs, e.ls, e.rgb);
      end
    end
    if (reset_n !== 1'b1) have_fs = 1'b0;
    else if (frame_start === 1'b1) begin
      if (have_fs) begin
        n_checks++;
        if (cyc - last_fs != 128) begin
          n_errors++;
          $display("FAIL frame_period: got %0d cycles, want 128", cyc - last_fs);
        end
      end
      last_fs = cyc;
      have_fs = 1'b1;
    end
  end

  initial begin
    reset_n   = 1'b0;
    layer_rgb = '0;
    layer_en  = '0;
    @(posedge clk); #1;
    repeat (5) step(1'b0);
    mode = 0;
    repeat (270) step(1'b1);
    mode = 1;
    repeat (270) step(1'b1);
    // one-cycle reset while the raster issues x=5, y=2
    while ((k % 128) != 37) step(1'b1);
    step(1'b0);
    mode = 0;
    repeat (300) step(1'b1);
`ifdef VIDEO_TEST_PATTERN_EN
    mode = 2;
    repeat (140) step(1'b1);
`endif
    @(negedge clk); #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: got %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
